decode_bundle_skid_queue: RTL and testbench
===========================================

// Module: decode_bundle_skid_queue
// PURPOSE
//  Two-entry bundle queue between the decode stage and the instruction buffer.
//  Decode delivers up to 2*FETCH_WIDTH decoded packets per bundle, each with a valid bit.
//  This block holds each bundle and presents it to the instruction buffer as decodeReady/decodedVector/decodedPacketN.
//  It keeps presenting the head bundle until the buffer's stallFetch is low, so no bundle is lost or duplicated.
// PARAMETERS
//  FETCH_WIDTH  4    fetch bandwidth; one bundle carries NSLOT = 2*FETCH_WIDTH packet slots
//  PKT_W        64   width of one decoded packet, in bits
//  DEPTH_LOG    1    log2 of the queue depth; fixed at 1, so DEPTH = 2 bundles
// PORTS
//  clk                 in   1             clock; all state updates on posedge clk
//  reset               in   1             synchronous, active-high reset
//  flush_i             in   1             control mispredict; discard every held bundle
//  bundle_valid_i      in   1             decode offers a bundle this cycle
//  bundle_vector_i     in   NSLOT         per-slot valid bits of the offered bundle
//  bundle_packets_i    in   NSLOT*PKT_W   slot k = bits [k*PKT_W +: PKT_W]
//  bundle_ready_o      out  1             queue can accept a bundle this cycle
//  stall_fetch_i       in   1             instruction buffer full; head bundle must be held
//  decode_ready_o      out  1             head bundle valid (drives the buffer's decodeReady)
//  decoded_vector_o    out  NSLOT         head bundle per-slot valid bits
//  decoded_packets_o   out  NSLOT*PKT_W   head bundle packets, same slot packing as input
//  head_inst_count_o   out  log2(NSLOT)+1 popcount of decoded_vector_o; 0 when empty
//  occupancy_o         out  2             number of bundles held: 0, 1 or 2
// BEHAVIOUR
//  - Reset, and flush_i, both clear the queue on the next edge. After that edge:
//    occupancy=0, decode_ready_o=0, vector=0, packets=0, count=0, bundle_ready_o=1.
//  - reset and flush_i take priority over push and pop in the same cycle.
//    A bundle offered in a flush cycle is discarded.
//  - Storage: 2 bundle registers, rd_ptr/wr_ptr 1 bit each, occupancy counter 0..2.
//    Pointers wrap 1->0.
//  - Outputs are driven only from registers, with no combinational path from any input:
//    decode_ready_o = (occupancy != 0); vector/packets = entry[rd_ptr] when occupancy != 0, else 0.
//  - bundle_ready_o = (occupancy < 2). It does not depend on stall_fetch_i.
//  - push = bundle_valid_i & bundle_ready_o & (bundle_vector_i != 0).
//    A bundle whose vector is all zero is accepted (handshake completes) but never stored.
//  - pop = decode_ready_o & ~stall_fetch_i. The buffer writes the head bundle in the same cycle.
//  - Latency: a bundle pushed in cycle N is visible on the outputs in cycle N+1 when the queue was empty.
//  - Simultaneous push and pop:
//    - occupancy 1: occupancy stays 1; the new bundle is the head from the next cycle.
//    - occupancy 2: push is impossible because bundle_ready_o = 0.
//  - Ordering is strict FIFO. No slot compaction: vector bits pass through unchanged.
//  - Reset or flush mid-stall clears the held bundles. Nothing is presented afterwards until a new push.
//  - Assertions (simulation only):
//    - occupancy never exceeds 2;
//    - head outputs stay stable while decode_ready_o & stall_fetch_i;
//    - bundle_valid_i is not held in a useful way when bundle_ready_o = 0 (decode must hold it).
// TESTING
//  1. Reset, then push vector=8'h0F, packets slot k = k+1, with no stall.
//     -> Next cycle decode_ready_o=1, vector=8'h0F, count=4. Popped that cycle; occupancy returns to 0.
//  2. stall_fetch_i=1 while pushing three bundles A, B, C.
//     -> A and B accepted; bundle_ready_o=0 while C is offered; outputs hold A unchanged.
//     -> Release stall: A, B, C appear in order on three consecutive cycles.
//  3. Occupancy 1 with push and pop in the same cycle (A head, B offered).
//     -> Occupancy stays 1; next cycle the head is B.
//  4. Push bundle_vector_i=8'h00 with bundle_valid_i=1.
//     -> bundle_ready_o=1, occupancy unchanged, decode_ready_o stays 0.
//  5. Occupancy 2 with stall; assert flush_i together with a new push.
//     -> Next cycle occupancy=0, decode_ready_o=0, all outputs 0; the new bundle is discarded.
//  6. Vector 8'hFF with stall toggling every cycle.
//     -> Each bundle is presented exactly once per ~stall cycle, count=8, no loss or duplication vs scoreboard.

Source files
------------

// File: rtl/decode_bundle_skid_queue_if.sv
// Decode-to-instruction-buffer bundle channel: offered bundle, flush and stall in; head bundle out.
// The queue side uses the slave modport; decode/buffer side uses master.
interface decode_bundle_skid_queue_if #(
    parameter int FETCH_WIDTH = 4,
    parameter int PKT_W       = 64
);
    localparam int NSLOT = 2 * FETCH_WIDTH;
    localparam int CNT_W = $clog2(NSLOT) + 1;

    logic                     flush_i;
    logic                     bundle_valid_i;
    logic [NSLOT-1:0]         bundle_vector_i;
    logic [NSLOT*PKT_W-1:0]   bundle_packets_i;
    logic                     bundle_ready_o;
    logic                     stall_fetch_i;
    logic                     decode_ready_o;
    logic [NSLOT-1:0]         decoded_vector_o;
    logic [NSLOT*PKT_W-1:0]   decoded_packets_o;
    logic [CNT_W-1:0]         head_inst_count_o;
    logic [1:0]               occupancy_o;

    modport master (
        output flush_i, bundle_valid_i, bundle_vector_i, bundle_packets_i, stall_fetch_i,
        input  bundle_ready_o, decode_ready_o, decoded_vector_o, decoded_packets_o,
               head_inst_count_o, occupancy_o
    );

    modport slave (
        input  flush_i, bundle_valid_i, bundle_vector_i, bundle_packets_i, stall_fetch_i,
        output bundle_ready_o, decode_ready_o, decoded_vector_o, decoded_packets_o,
               head_inst_count_o, occupancy_o
    );
endinterface

// File: rtl/decode_bundle_skid_queue.sv
// Two-entry FIFO of decoded bundles feeding the instruction buffer; a push shows on the outputs next cycle.
// Backpressure: bundle_ready_o drops when both entries are held; the head is held while stall_fetch_i is high.
module decode_bundle_skid_queue #(
    parameter int FETCH_WIDTH = 4,
    parameter int PKT_W       = 64,
    parameter int DEPTH_LOG   = 1
) (
    input logic                       clk,
    input logic                       reset,
    decode_bundle_skid_queue_if.slave bus
);
    localparam int NSLOT = 2 * FETCH_WIDTH;
    localparam int CNT_W = $clog2(NSLOT) + 1;
    localparam int DEPTH = 1 << DEPTH_LOG;

    typedef struct packed {
        logic [NSLOT-1:0]       vector;
        logic [NSLOT*PKT_W-1:0] packets;
    } bundle_t;

    bundle_t              entry [DEPTH];
    logic [DEPTH_LOG-1:0] rdPtr;
    logic [DEPTH_LOG-1:0] wrPtr;
    logic [1:0]           occCount;
    logic                 notEmpty;
    logic                 canAccept;
    logic                 pushEn;
    logic                 popEn;
    bundle_t              headBundle;
    logic [CNT_W-1:0]     headCount;

    assign notEmpty  = (occCount != 2'd0);
    assign canAccept = (occCount < 2'(DEPTH));
    // An all-zero bundle completes the handshake but carries nothing worth storing.
    assign pushEn    = bus.bundle_valid_i & canAccept & (|bus.bundle_vector_i);
    assign popEn     = notEmpty & ~bus.stall_fetch_i;

    always_ff @(posedge clk) begin
        if (reset || bus.flush_i) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            occCount <= 2'd0;
        end else begin
            if (pushEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popEn) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({pushEn, popEn})
                2'b10:   occCount <= occCount + 2'd1;
                2'b01:   occCount <= occCount - 2'd1;
                default: occCount <= occCount;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) begin
            entry[wrPtr] <= '{vector: bus.bundle_vector_i, packets: bus.bundle_packets_i};
        end
    end

    // Head is gated to zero when empty so stale entries never leak to the buffer.
    assign headBundle = notEmpty ? entry[rdPtr] : '0;

    always_comb begin
        headCount = '0;
        for (int i = 0; i < NSLOT; i++) begin
            headCount = headCount + CNT_W'(headBundle.vector[i]);
        end
    end

    assign bus.bundle_ready_o    = canAccept;
    assign bus.decode_ready_o    = notEmpty;
    assign bus.decoded_vector_o  = headBundle.vector;
    assign bus.decoded_packets_o = headBundle.packets;
    assign bus.head_inst_count_o = headCount;
    assign bus.occupancy_o       = occCount;

    occBound: assert property (@(posedge clk) disable iff (reset) occCount <= 2'd2);

    headStableOnStall: assert property (@(posedge clk) disable iff (reset)
        (bus.decode_ready_o && bus.stall_fetch_i && !bus.flush_i)
        |=> ($stable(bus.decoded_vector_o) && $stable(bus.decoded_packets_o)));

    offerHeldWhenFull: assert property (@(posedge clk) disable iff (reset)
        (bus.bundle_valid_i && !bus.bundle_ready_o && !bus.flush_i) |=> bus.bundle_valid_i);
endmodule

// File: tb/tb_decode_bundle_skid_queue.sv
// Randomized bench for the decode bundle queue: stimulus pushes accepted bundles into a scoreboard
// queue, a negedge monitor compares every head presentation and pops on each buffer write.
module tb_decode_bundle_skid_queue;
    localparam int FW    = 4;
    localparam int PKT_W = 64;
    localparam int NSLOT = 2 * FW;
    localparam int PW    = NSLOT * PKT_W;

    typedef struct {
        logic [NSLOT-1:0] vector;
        logic [PW-1:0]    packets;
    } bundle_t;

    logic clk = 1'b0;
    logic reset;

    decode_bundle_skid_queue_if #(.FETCH_WIDTH(FW), .PKT_W(PKT_W)) bus ();

    decode_bundle_skid_queue #(.FETCH_WIDTH(FW), .PKT_W(PKT_W), .DEPTH_LOG(1)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    bundle_t expq[$];
    int      nChecks   = 0;
    int      nFails    = 0;
    bit      started   = 1'b0;
    int      stallMode = 0;   // 0 low, 1 high, 2 toggle, 3 random

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] randPkts();
        logic [PW-1:0] r;
        for (int i = 0; i < PW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [NSLOT-1:0] randVec();
        int k;
        k = $urandom_range(0, 7);
        if (k == 0) return '0;
        if (k == 1) return '1;
        return NSLOT'($urandom);
    endfunction

    // Stall generator for the instruction buffer side.
    initial begin
        bus.stall_fetch_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (stallMode)
                0:       bus.stall_fetch_i = 1'b0;
                1:       bus.stall_fetch_i = 1'b1;
                2:       bus.stall_fetch_i = ~bus.stall_fetch_i;
                default: bus.stall_fetch_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares the presented head against the model, then applies pop/flush/reset.
    initial begin
        int      sz;
        bundle_t hd;
        forever begin
            @(negedge clk);
            if (started) begin
                sz = expq.size();
                chk("occupancy", PW'(bus.occupancy_o), PW'(sz));
                chk("decode_ready", PW'(bus.decode_ready_o), PW'(sz != 0));
                chk("bundle_ready", PW'(bus.bundle_ready_o), PW'(sz < 2));
                if (sz != 0) begin
                    hd = expq[0];
                    chk("head_vector", PW'(bus.decoded_vector_o), PW'(hd.vector));
                    chk("head_packets", bus.decoded_packets_o, hd.packets);
                    chk("head_count", PW'(bus.head_inst_count_o), PW'($countones(hd.vector)));
                end else begin
                    chk("empty_vector", PW'(bus.decoded_vector_o), '0);
                    chk("empty_packets", bus.decoded_packets_o, '0);
                    chk("empty_count", PW'(bus.head_inst_count_o), '0);
                end
                if (reset || bus.flush_i) expq.delete();
                else if (sz != 0 && !bus.stall_fetch_i) void'(expq.pop_front());
            end
        end
    end

    // One cycle of decode-side drive; acc reports a completed handshake.
    task automatic step(input bit v, input logic [NSLOT-1:0] vec, input logic [PW-1:0] p,
                        input bit fl, output bit acc);
        @(posedge clk);
        #1;
        bus.bundle_valid_i   = v;
        bus.bundle_vector_i  = vec;
        bus.bundle_packets_i = p;
        bus.flush_i          = fl;
        @(negedge clk);
        #1;
        acc = v && bus.bundle_ready_o && !reset;
        if (acc && vec != '0 && !fl) expq.push_back('{vector: vec, packets: p});
    endtask

    task automatic send(input logic [NSLOT-1:0] vec, input logic [PW-1:0] p);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        while (!acc) begin
            step(1'b1, vec, p, 1'b0, acc);
            guard++;
            if (!acc && guard > 500) begin
                nChecks++;
                nFails++;
                $display("FAIL send_timeout: got no handshake required one within 500 cycles");
                acc = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.bundle_valid_i  = 1'b0;
            bus.bundle_vector_i = '0;
            bus.flush_i         = 1'b0;
        end
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        reset              = 1'b1;
        bus.bundle_valid_i = 1'b0;
        bus.flush_i        = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] p;
        bit            acc;
        bus.flush_i          = 1'b0;
        bus.bundle_valid_i   = 1'b0;
        bus.bundle_vector_i  = '0;
        bus.bundle_packets_i = '0;
        reset                = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single bundle, slot k carries k+1, no stall.
        p = '0;
        for (int k = 0; k < NSLOT; k++) p[k*PKT_W +: PKT_W] = PKT_W'(k + 1);
        send(8'h0F, p);
        idle(3);

        // Fill under stall, third offer waits, then drain in order.
        stallMode = 1;
        idle(1);
        send(8'h11, randPkts());
        send(8'h22, randPkts());
        fork
            send(8'h33, randPkts());
            begin
                repeat (4) @(negedge clk);
                stallMode = 0;
            end
        join
        idle(4);

        // Back-to-back pushes with no stall exercise push+pop at occupancy 1.
        send(8'hA1, randPkts());
        send(8'hB2, randPkts());
        send(8'hC3, randPkts());
        idle(3);

        // All-zero vector is accepted but not stored.
        send(8'h00, randPkts());
        idle(2);

        // Flush while full with a new offer; then flush with room available.
        stallMode = 1;
        idle(1);
        send(8'h5A, randPkts());
        send(8'hA5, randPkts());
        step(1'b1, 8'h77, randPkts(), 1'b1, acc);
        idle(3);
        send(8'h3C, randPkts());
        step(1'b1, 8'h66, randPkts(), 1'b1, acc);
        idle(2);

        // Reset mid-stall with two bundles held.
        send(8'h12, randPkts());
        send(8'h34, randPkts());
        pulseReset();
        idle(2);
        stallMode = 0;
        idle(2);

        // Full vectors with stall toggling each cycle.
        stallMode = 2;
        for (int i = 0; i < 10; i++) send(8'hFF, randPkts());
        stallMode = 0;
        idle(4);

        // Randomized traffic with random stall, gaps and occasional flush.
        stallMode = 3;
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 2) idle($urandom_range(1, 2));
            else if (r == 2) step(1'($urandom_range(0, 1)), randVec(), randPkts(), 1'b1, acc);
            else send(randVec(), randPkts());
        end
        stallMode = 0;
        idle(6);
        chk("drain_empty", PW'(expq.size()), '0);
        chk("drain_occupancy", PW'(bus.occupancy_o), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
